// File: rtl/ps2_dev_tx.sv
// PS/2 device-side transmitter: serialises one byte per handshake into an 11-bit
// frame and generates the PS/2 clock itself on open-drain (drive-low/release) lines.
module ps2_dev_tx #(
    parameter int CLK_DIV  = 2500,
    parameter int IDLE_CYC = 2500
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic [7:0] tx_data_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       abort_o,
    input  logic       ps2_clk_i,
    output logic       ps2_clk_oe_o,
    input  logic       ps2_dat_i,
    output logic       ps2_dat_oe_o
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = $clog2(IDLE_CYC + 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYC);

    // IDLE: wait for quiet bus | SETUP: present bit, clock released | LOW: clock driven low | HOLD: recovery after stop
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_LOW   = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [3:0]    bit_q, bit_d;
    logic [10:0]   frame_q, frame_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          done_q, done_d;
    logic          abort_q, abort_d;
    logic          bus_idle;
    logic          phase_end;

    assign bus_idle     = (idle_q == IDLE_MAX);
    assign phase_end    = (phase_q == PH_LAST);
    assign tx_ready_o   = (state_q == ST_IDLE) && bus_idle;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;
    assign abort_o      = abort_q;
    // Outputs decode straight from state so an async reset releases both lines at once.
    assign ps2_clk_oe_o = (state_q == ST_LOW);
    assign ps2_dat_oe_o = ((state_q == ST_SETUP) || (state_q == ST_LOW)) && !frame_q[bit_q];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_s1_q <= 1'b0;
            clk_s2_q <= 1'b0;
            dat_s1_q <= 1'b0;
            dat_s2_q <= 1'b0;
        end else begin
            clk_s1_q <= ps2_clk_i;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat_i;
            dat_s2_q <= dat_s1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        idle_d  = idle_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                if (clk_s2_q && dat_s2_q) begin
                    if (!bus_idle) idle_d = idle_q + IW'(1);
                end else begin
                    idle_d = '0;
                end
                if (tx_valid_i && tx_ready_o) begin
                    frame_d = {1'b1, ~^tx_data_i, tx_data_i, 1'b0};
                    bit_d   = 4'd0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                phase_d = phase_q + PW'(1);
                if (phase_end) begin
                    phase_d = '0;
                    // Host inhibit, or host holding data low against a released 1 bit.
                    if (!clk_s2_q || (frame_q[bit_q] && !dat_s2_q)) begin
                        state_d = ST_IDLE;
                        abort_d = 1'b1;
                        idle_d  = '0;
                    end else begin
                        state_d = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                phase_d = phase_q + PW'(1);
                if (phase_end) begin
                    phase_d = '0;
                    if (bit_q == 4'd10) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = ST_SETUP;
                    end
                end
            end
            default: begin
                phase_d = phase_q + PW'(1);
                if (phase_end) begin
                    phase_d = '0;
                    done_d  = 1'b1;
                    idle_d  = '0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            bit_q   <= 4'd0;
            frame_q <= 11'd0;
            idle_q  <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            idle_q  <= idle_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end
endmodule

// File: tb/tb_ps2_dev_tx.sv
// Directed bench for ps2_dev_tx with open-drain pull-up line model and a host
// that records the data line on every device-generated falling clock edge.
module tb_ps2_dev_tx;
    localparam int CLK_DIV  = 8;
    localparam int IDLE_CYC = 16;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       tx_valid_i = 1'b0;
    logic [7:0] tx_data_i = 8'h00;
    logic       host_clk_pull = 1'b0;
    logic       host_dat_pull = 1'b0;
    logic       tx_ready_o, busy_o, done_o, abort_o, ps2_clk_oe_o, ps2_dat_oe_o;
    logic       ps2_clk_line, ps2_dat_line;

    assign ps2_clk_line = ~(ps2_clk_oe_o | host_clk_pull);
    assign ps2_dat_line = ~(ps2_dat_oe_o | host_dat_pull);

    ps2_dev_tx #(.CLK_DIV(CLK_DIV), .IDLE_CYC(IDLE_CYC)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i),
        .busy_o(busy_o), .done_o(done_o), .abort_o(abort_o),
        .ps2_clk_i(ps2_clk_line), .ps2_clk_oe_o(ps2_clk_oe_o),
        .ps2_dat_i(ps2_dat_line), .ps2_dat_oe_o(ps2_dat_oe_o)
    );

    int   checks = 0;
    int   failures = 0;
    int   cap_cnt = 0, done_cnt = 0, abort_cnt = 0;
    time  cap_time = 0, done_time = 0, abort_time = 0;
    logic abort_oe = 1'b0;
    logic edge_bits[$];
    time  edge_times[$];

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i)
        if (rst_n_i && tx_valid_i && tx_ready_o) begin
            cap_cnt++;
            cap_time = $time;
        end

    always @(negedge clk_i) begin
        if (done_o) begin
            done_cnt++;
            done_time = $time;
        end
        if (abort_o) begin
            abort_cnt++;
            abort_time = $time;
            abort_oe = ps2_clk_oe_o | ps2_dat_oe_o;
        end
    end

    always @(negedge ps2_clk_line)
        if (ps2_clk_oe_o) begin
            edge_bits.push_back(ps2_dat_line);
            edge_times.push_back($time);
        end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic wait_cap(input int c0, input string tag);
        int n = 0;
        while (cap_cnt == c0 && n < 2000) begin tick(); n++; end
        checks++;
        if (cap_cnt == c0) begin
            failures++;
            $display("FAIL %s_capture: no capture seen, required one within 2000 cycles", tag);
        end
    endtask

    task automatic wait_done(input int d0, input string tag);
        int n = 0;
        while (done_cnt == d0 && n < 2000) begin tick(); n++; end
        checks++;
        if (done_cnt == d0) begin
            failures++;
            $display("FAIL %s_done: no done_o seen, required one within 2000 cycles", tag);
        end
    endtask

    task automatic wait_abort(input int a0, input string tag);
        int n = 0;
        while (abort_cnt == a0 && n < 2000) begin tick(); n++; end
        checks++;
        if (abort_cnt == a0) begin
            failures++;
            $display("FAIL %s_abort: no abort_o seen, required one within 2000 cycles", tag);
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n_i = 1'b0;
        repeat (3) tick();
        checks++;
        if ({tx_ready_o, busy_o, done_o, abort_o} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: got ready/busy/done/abort=%b, required 0000",
                     {tx_ready_o, busy_o, done_o, abort_o});
        end
        checks++;
        if ({ps2_clk_oe_o, ps2_dat_oe_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_oe: got %b, required 00", {ps2_clk_oe_o, ps2_dat_oe_o});
        end
        rst_n_i = 1'b1;
        n = 0;
        while (!tx_ready_o && n < 100) begin tick(); n++; end
        checks++;
        if (n != 18) begin
            failures++;
            $display("FAIL reset_ready_delay: got %0d cycles, required 18", n);
        end
    endtask

    task automatic test_single();
        int d0, n;
        logic [10:0] got;
        logic bad;
        edge_bits.delete();
        edge_times.delete();
        d0 = done_cnt;
        tx_data_i = 8'h1C;
        tx_valid_i = 1'b1;
        wait_cap(cap_cnt, "single");
        tx_valid_i = 1'b0;
        tx_data_i = 8'hA5;
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL single_busy_start: got %b, required 1", busy_o);
        end
        wait_done(d0, "single");
        got = '0;
        for (int i = 0; i < edge_bits.size() && i < 11; i++) got[i] = edge_bits[i];
        checks++;
        if (edge_bits.size() != 11 || got !== 11'h438) begin
            failures++;
            $display("FAIL single_bits: got %0d edges bits %b, required 11 edges bits %b",
                     edge_bits.size(), got, 11'h438);
        end
        bad = 1'b0;
        for (int i = 0; i < edge_times.size(); i++)
            if (edge_times[i] != cap_time + 80 + 160 * i) bad = 1'b1;
        checks++;
        if (bad || edge_times.size() == 0) begin
            failures++;
            $display("FAIL single_edge_timing: got first edge at capture+%0t, required capture+80 and 160 spacing",
                     (edge_times.size() > 0) ? edge_times[0] - cap_time : 0);
        end
        checks++;
        if (done_time != cap_time + 1845) begin
            failures++;
            $display("FAIL single_done_time: got capture+%0t, required capture+1845", done_time - cap_time);
        end
        tick();
        checks++;
        if ({busy_o, done_o} !== 2'b00) begin
            failures++;
            $display("FAIL single_after_done: got busy/done=%b, required 00", {busy_o, done_o});
        end
        n = 1;
        while (!tx_ready_o && n < 100) begin tick(); n++; end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL single_ready_delay: got %0d cycles after done, required 16", n);
        end
        repeat (4) tick();
        checks++;
        if (done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL single_done_pulses: got %0d, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int c0, d0;
        time d_time;
        logic [10:0] got;
        c0 = cap_cnt;
        d0 = done_cnt;
        edge_bits.delete();
        tx_data_i = 8'h01;
        tx_valid_i = 1'b1;
        wait_cap(c0, "b2b_first");
        tx_data_i = 8'hFF;
        wait_done(d0, "b2b_first");
        got = '0;
        for (int i = 0; i < edge_bits.size() && i < 11; i++) got[i] = edge_bits[i];
        checks++;
        if (edge_bits.size() != 11 || got !== 11'h402) begin
            failures++;
            $display("FAIL b2b_bits_01: got %0d edges bits %b, required 11 edges bits %b",
                     edge_bits.size(), got, 11'h402);
        end
        edge_bits.delete();
        d_time = done_time;
        wait_cap(c0 + 1, "b2b_second");
        tx_valid_i = 1'b0;
        checks++;
        if (cap_time != d_time + 165) begin
            failures++;
            $display("FAIL b2b_gap: got second capture at done+%0t, required done+165", cap_time - d_time);
        end
        wait_done(d0 + 1, "b2b_second");
        got = '0;
        for (int i = 0; i < edge_bits.size() && i < 11; i++) got[i] = edge_bits[i];
        checks++;
        if (edge_bits.size() != 11 || got !== 11'h7FE) begin
            failures++;
            $display("FAIL b2b_bits_ff: got %0d edges bits %b, required 11 edges bits %b",
                     edge_bits.size(), got, 11'h7FE);
        end
        repeat (4) tick();
        checks++;
        if (cap_cnt != c0 + 2) begin
            failures++;
            $display("FAIL b2b_captures: got %0d, required 2", cap_cnt - c0);
        end
    endtask

    task automatic test_abort_clk();
        int a0, d0, n;
        a0 = abort_cnt;
        d0 = done_cnt;
        tx_data_i = 8'h55;
        tx_valid_i = 1'b1;
        wait_cap(cap_cnt, "abort_clk");
        tx_valid_i = 1'b0;
        repeat (65) tick();
        host_clk_pull = 1'b1;
        wait_abort(a0, "abort_clk");
        checks++;
        if (abort_time != cap_time + 725) begin
            failures++;
            $display("FAIL abort_clk_time: got capture+%0t, required capture+725", abort_time - cap_time);
        end
        checks++;
        if (abort_oe !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_clk_release: got oe=%b busy=%b, required 0 0", abort_oe, busy_o);
        end
        repeat (7) tick();
        host_clk_pull = 1'b0;
        n = 0;
        while (!tx_ready_o && n < 100) begin tick(); n++; end
        checks++;
        if (n != 18) begin
            failures++;
            $display("FAIL abort_clk_ready_delay: got %0d cycles, required 18", n);
        end
        checks++;
        if (done_cnt != d0 || abort_cnt != a0 + 1) begin
            failures++;
            $display("FAIL abort_clk_pulses: got done=%0d abort=%0d, required 0 1", done_cnt - d0, abort_cnt - a0);
        end
    endtask

    task automatic test_abort_dat();
        int a0, d0;
        a0 = abort_cnt;
        d0 = done_cnt;
        tx_data_i = 8'h04;
        tx_valid_i = 1'b1;
        wait_cap(cap_cnt, "abort_dat");
        tx_valid_i = 1'b0;
        host_dat_pull = 1'b1;
        wait_abort(a0, "abort_dat");
        checks++;
        if (abort_time != cap_time + 565) begin
            failures++;
            $display("FAIL abort_dat_time: got capture+%0t, required capture+565", abort_time - cap_time);
        end
        checks++;
        if (abort_oe !== 1'b0 || done_cnt != d0) begin
            failures++;
            $display("FAIL abort_dat_release: got oe=%b done=%0d, required 0 0", abort_oe, done_cnt - d0);
        end
        host_dat_pull = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset_idle();
        int c0, n;
        logic seen;
        rst_n_i = 1'b0;
        host_clk_pull = 1'b1;
        repeat (2) tick();
        rst_n_i = 1'b1;
        c0 = cap_cnt;
        tx_data_i = 8'h33;
        tx_valid_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx_ready_o) seen = 1'b1;
        end
        checks++;
        if (seen || cap_cnt != c0) begin
            failures++;
            $display("FAIL held_low_ignored: got ready_seen=%b captures=%0d, required 0 0", seen, cap_cnt - c0);
        end
        tx_valid_i = 1'b0;
        host_clk_pull = 1'b0;
        n = 0;
        while (!tx_ready_o && n < 100) begin tick(); n++; end
        checks++;
        if (n != 18) begin
            failures++;
            $display("FAIL held_low_ready_delay: got %0d cycles, required 18", n);
        end
    endtask

    task automatic test_reset_mid();
        int a0, d0;
        a0 = abort_cnt;
        d0 = done_cnt;
        tx_data_i = 8'h3C;
        tx_valid_i = 1'b1;
        wait_cap(cap_cnt, "reset_mid");
        tx_valid_i = 1'b0;
        repeat (106) tick();
        checks++;
        if (ps2_clk_oe_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_low_phase: got clk_oe=%b, required 1", ps2_clk_oe_o);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if ({ps2_clk_oe_o, ps2_dat_oe_o, busy_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid_async: got clk_oe/dat_oe/busy=%b, required 000",
                     {ps2_clk_oe_o, ps2_dat_oe_o, busy_o});
        end
        repeat (2) tick();
        rst_n_i = 1'b1;
        repeat (10) tick();
        checks++;
        if (done_cnt != d0 || abort_cnt != a0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_after: got done=%0d abort=%0d busy=%b, required 0 0 0",
                     done_cnt - d0, abort_cnt - a0, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_abort_clk();
        test_abort_dat();
        test_reset_idle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
